// File: rtl/tb_commit_checker.sv
// Lockstep commit checker: pairs core and reference-model retirements in
// order, counts matches/mismatches and flags overflow or one-sided stalls.
module tb_commit_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_dut_valid,
    input  logic              i_dut_kind,
    input  logic [DATA_W-1:0] i_dut_addr,
    input  logic [DATA_W-1:0] i_dut_data,
    input  logic              i_ref_valid,
    input  logic              i_ref_kind,
    input  logic [DATA_W-1:0] i_ref_addr,
    input  logic [DATA_W-1:0] i_ref_data,
    output logic              o_ref_ready,
    input  logic              i_drain,
    output logic [15:0]       o_match_count,
    output logic [15:0]       o_err_count,
    output logic              o_mismatch,
    output logic [DATA_W-1:0] o_mis_addr,
    output logic              o_overflow,
    output logic              o_timeout,
    output logic              o_done,
    output logic              o_pass
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 2 * DATA_W + 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [IW-1:0] TMAX = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     dut_mem_q [DEPTH];
    logic [EW-1:0]     ref_mem_q [DEPTH];
    logic [AW-1:0]     dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
    logic [AW-1:0]     ref_wr_q, ref_wr_d, ref_rd_q, ref_rd_d;
    logic [CW-1:0]     dut_cnt_q, dut_cnt_d, ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]     idle_q, idle_d;
    logic [15:0]       match_q, match_d, err_q, err_d;
    logic [DATA_W-1:0] mis_addr_q, mis_addr_d;
    logic              mis_seen_q, mis_seen_d;
    logic              mis_pulse_q, mis_pulse_d;
    logic              ovf_q, ovf_d, to_q, to_d;

    logic              active, dut_empty, ref_empty, dut_full, ref_full;
    logic              dut_req, dut_push, ref_push, cmp, differ, to_evt;
    logic [EW-1:0]     dut_head, ref_head;
    logic [16:0]       err_sum;

    assign active    = (state_q != S_DONE);
    assign dut_empty = (dut_cnt_q == '0);
    assign ref_empty = (ref_cnt_q == '0);
    assign dut_full  = (dut_cnt_q == FULL);
    assign ref_full  = (ref_cnt_q == FULL);
    assign dut_head  = dut_mem_q[dut_rd_q];
    assign ref_head  = ref_mem_q[ref_rd_q];
    assign cmp       = active && !dut_empty && !ref_empty;
    assign differ    = (dut_head != ref_head);

    // Writes to x0 never retire architecturally, so they are not compared
    assign dut_req  = active && i_dut_valid
                    && (i_dut_kind || (i_dut_addr != '0));
    assign dut_push = dut_req && (!dut_full || cmp);

    assign o_ref_ready = i_rstn && active && !ref_full;
    assign ref_push    = o_ref_ready && i_ref_valid
                       && (i_ref_kind || (i_ref_addr != '0));

    always_comb begin
        dut_wr_d  = dut_wr_q + AW'(dut_push);
        dut_rd_d  = dut_rd_q + AW'(cmp);
        dut_cnt_d = dut_cnt_q + CW'(dut_push) - CW'(cmp);
        ref_wr_d  = ref_wr_q + AW'(ref_push);
        ref_rd_d  = ref_rd_q + AW'(cmp);
        ref_cnt_d = ref_cnt_q + CW'(ref_push) - CW'(cmp);
    end

    always_comb begin
        idle_d = idle_q;
        if (active) begin
            if (dut_empty != ref_empty) begin
                idle_d = (idle_q == TMAX) ? idle_q : idle_q + IW'(1);
            end else begin
                idle_d = '0;
            end
        end
        to_evt = active && !to_q && (idle_d == TMAX);
        to_d   = to_q | to_evt;
        ovf_d  = ovf_q | (dut_req && !dut_push);
    end

    always_comb begin
        match_d = match_q;
        if (cmp && !differ && (match_q != 16'hFFFF)) begin
            match_d = match_q + 16'd1;
        end
        err_sum = {1'b0, err_q} + 17'(cmp && differ) + 17'(to_evt);
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        mis_pulse_d = cmp && differ;
        mis_seen_d  = mis_seen_q;
        mis_addr_d  = mis_addr_q;
        if (mis_pulse_d && !mis_seen_q) begin
            mis_seen_d = 1'b1;
            mis_addr_d = dut_head[EW-2 -: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (i_drain) state_d = S_DRAIN;
            S_DRAIN: begin
                if (((dut_cnt_d == '0) && (ref_cnt_d == '0)) || to_d) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase
    end

    // Storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge i_clk) begin
        if (dut_push) dut_mem_q[dut_wr_q] <= {i_dut_kind, i_dut_addr, i_dut_data};
        if (ref_push) ref_mem_q[ref_wr_q] <= {i_ref_kind, i_ref_addr, i_ref_data};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_RUN;
            dut_wr_q    <= '0;
            dut_rd_q    <= '0;
            dut_cnt_q   <= '0;
            ref_wr_q    <= '0;
            ref_rd_q    <= '0;
            ref_cnt_q   <= '0;
            idle_q      <= '0;
            match_q     <= '0;
            err_q       <= '0;
            mis_addr_q  <= '0;
            mis_seen_q  <= 1'b0;
            mis_pulse_q <= 1'b0;
            ovf_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dut_wr_q    <= dut_wr_d;
            dut_rd_q    <= dut_rd_d;
            dut_cnt_q   <= dut_cnt_d;
            ref_wr_q    <= ref_wr_d;
            ref_rd_q    <= ref_rd_d;
            ref_cnt_q   <= ref_cnt_d;
            idle_q      <= idle_d;
            match_q     <= match_d;
            err_q       <= err_d;
            mis_addr_q  <= mis_addr_d;
            mis_seen_q  <= mis_seen_d;
            mis_pulse_q <= mis_pulse_d;
            ovf_q       <= ovf_d;
            to_q        <= to_d;
        end
    end

    assign o_match_count = match_q;
    assign o_err_count   = err_q;
    assign o_mismatch    = mis_pulse_q;
    assign o_mis_addr    = mis_addr_q;
    assign o_overflow    = ovf_q;
    assign o_timeout     = to_q;
    assign o_done        = (state_q == S_DONE);
    assign o_pass        = o_done && (err_q == '0) && !ovf_q && !to_q;
endmodule

// File: tb/tb_tb_commit_checker.sv
// Bench for tb_commit_checker: directed scenarios plus randomized lockstep
// traffic, scored against an index-paired reference model.
module tb_tb_commit_checker;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    typedef struct packed {
        logic          kind;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } commit_t;

    typedef struct {
        bit            eq;
        logic [DW-1:0] addr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          dut_valid, dut_kind, ref_valid, ref_kind, drain;
    logic [DW-1:0] dut_addr, dut_data, ref_addr, ref_data;
    logic          ref_ready, mismatch, ovf, tout, done, pass;
    logic [15:0]   match_cnt, err_cnt;
    logic [DW-1:0] mis_addr;

    commit_t mdq[$];
    commit_t mrq[$];
    commit_t mirror[$];
    exp_t    exp_q[$];
    int      n_tests = 0;
    int      n_fail = 0;
    int      pairs_eq, pairs_ne;

    always #5 clk = ~clk;

    tb_commit_checker #(
        .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_dut_valid(dut_valid), .i_dut_kind(dut_kind),
        .i_dut_addr(dut_addr), .i_dut_data(dut_data),
        .i_ref_valid(ref_valid), .i_ref_kind(ref_kind),
        .i_ref_addr(ref_addr), .i_ref_data(ref_data),
        .o_ref_ready(ref_ready), .i_drain(drain),
        .o_match_count(match_cnt), .o_err_count(err_cnt),
        .o_mismatch(mismatch), .o_mis_addr(mis_addr),
        .o_overflow(ovf), .o_timeout(tout),
        .o_done(done), .o_pass(pass)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic commit_t mk(logic k, logic [DW-1:0] a, logic [DW-1:0] d);
        commit_t c;
        c.kind = k;
        c.addr = a;
        c.data = d;
        return c;
    endfunction

    // Model: the i-th surviving core commit must equal the i-th model commit
    task automatic pair_up();
        commit_t d, r;
        while (mdq.size() > 0 && mrq.size() > 0) begin
            d = mdq.pop_front();
            r = mrq.pop_front();
            exp_q.push_back('{eq: (d == r), addr: d.addr});
            if (d == r) pairs_eq++;
            else pairs_ne++;
        end
    endtask

    task automatic put_dut(commit_t c);
        dut_valid = 1'b1;
        dut_kind  = c.kind;
        dut_addr  = c.addr;
        dut_data  = c.data;
        if (c.kind || c.addr != '0) begin
            mdq.push_back(c);
            pair_up();
        end
    endtask

    task automatic put_ref(commit_t c);
        ref_valid = 1'b1;
        ref_kind  = c.kind;
        ref_addr  = c.addr;
        ref_data  = c.data;
        if (c.kind || c.addr != '0) begin
            mrq.push_back(c);
            pair_up();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dut_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        drain = 1'b0;
        mdq.delete();
        mrq.delete();
        mirror.delete();
        exp_q.delete();
        pairs_eq = 0;
        pairs_ne = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_done(string name, int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk(name, done, 1);
    endtask

    // Monitor: every compare the DUT reports consumes one expected outcome
    logic [15:0]   m_prev;
    int            exp_match, exp_err;
    bit            m_seen;
    logic [DW-1:0] m_first;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (!rstn) begin
            m_prev    = '0;
            exp_match = 0;
            exp_err   = 0;
            m_seen    = 1'b0;
            m_first   = '0;
        end else if (match_cnt != m_prev || mismatch) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: match=%0d mis=%0b, no compare pending",
                         match_cnt, mismatch);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_outcome", mismatch, !mon_e.eq);
                if (mon_e.eq) begin
                    exp_match++;
                    chk("sb_match_cnt", match_cnt, exp_match);
                end else begin
                    exp_err++;
                    if (!m_seen) begin
                        m_seen  = 1'b1;
                        m_first = mon_e.addr;
                    end
                    chk("sb_err_cnt", err_cnt, exp_err);
                    chk("sb_mis_addr", mis_addr, m_first);
                end
            end
            m_prev = match_cnt;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        commit_t c;
        int      n;
        int      n_inj;
        dut_valid = 0; dut_kind = 0; dut_addr = '0; dut_data = '0;
        ref_valid = 0; ref_kind = 0; ref_addr = '0; ref_data = '0;
        drain = 0;
        pairs_eq = 0;
        pairs_ne = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ref_ready", ref_ready, 0);
        chk("rst_counts", {match_cnt, err_cnt}, 0);
        chk("rst_status", {mismatch, ovf, tout, done, pass}, 0);
        rstn = 1'b1;
        #1;
        chk("rel_ref_ready", ref_ready, 1);

        // Three matching commits, an ignored x0 write, then drain
        put_dut(mk(0, 0, 32'h9));
        tick();
        put_dut(mk(0, 5, 32'h10));
        put_ref(mk(0, 5, 32'h10));
        tick();
        @(negedge clk);
        chk("lat_before", match_cnt, 0);
        @(posedge clk);
        #1;
        chk("lat_after", match_cnt, 1);
        put_dut(mk(0, 6, 32'h20));
        put_ref(mk(0, 6, 32'h20));
        tick();
        put_dut(mk(1, 32'h100, 32'hAB));
        put_ref(mk(1, 32'h100, 32'hAB));
        tick();
        repeat (2) tick();
        chk("t1_match", match_cnt, 3);
        chk("t1_err", err_cnt, 0);
        drain = 1'b1;
        wait_done("t1_done", 10);
        chk("t1_pass", pass, 1);
        chk("t1_done_ready", ref_ready, 0);
        dut_valid = 1'b1; dut_kind = 0; dut_addr = 7; dut_data = 1;
        ref_valid = 1'b1; ref_kind = 0; ref_addr = 7; ref_data = 1;
        tick();
        repeat (2) tick();
        chk("t1_frozen", match_cnt, 3);
        chk("t1_still_done", {done, pass}, 2'b11);

        // Data mismatch, pulse width and first-address capture
        do_reset();
        put_dut(mk(0, 5, 32'h10));
        put_ref(mk(0, 5, 32'h11));
        tick();
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(mismatch);
        end
        @(posedge clk);
        #1;
        chk("t2_pulse_len", n, 1);
        put_dut(mk(0, 7, 32'h1));
        put_ref(mk(0, 7, 32'h2));
        tick();
        repeat (2) tick();
        chk("t2_err", err_cnt, 2);
        chk("t2_mis_addr", mis_addr, 5);
        drain = 1'b1;
        wait_done("t2_done", 10);
        chk("t2_pass", pass, 0);

        // Overflow boundary and discarded x0 writes on the model side
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            put_dut(mk(0, DW'(i + 1), DW'(i)));
            tick();
        end
        chk("t3_full_no_ovf", ovf, 0);
        put_dut(mk(0, 20, 1));
        tick();
        chk("t3_ovf", ovf, 1);
        chk("t3_ready", ref_ready, 1);
        repeat (4) begin
            put_ref(mk(0, 0, 32'h55));
            tick();
        end
        tick();
        chk("t3_ready_x0", ref_ready, 1);
        chk("t3_no_cmp", {match_cnt, err_cnt}, 0);

        // One-sided stall reaches timeout exactly TIMEOUT cycles later
        do_reset();
        put_dut(mk(0, 9, 9));
        tick();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        chk("t4_to_early", tout, 0);
        @(posedge clk);
        #1;
        chk("t4_to", tout, 1);
        chk("t4_err", err_cnt, 1);
        repeat (5) tick();
        chk("t4_err_once", err_cnt, 1);
        drain = 1'b1;
        wait_done("t4_done", 10);
        chk("t4_pass", pass, 0);

        // Reset with entries queued discards them
        do_reset();
        put_dut(mk(0, 3, 3));
        put_ref(mk(0, 3, 4));
        tick();
        for (int i = 0; i < 4; i++) begin
            put_dut(mk(0, DW'(i + 10), DW'(i)));
            tick();
        end
        chk("t5_pre_err", err_cnt, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_counts", {match_cnt, err_cnt}, 0);
        chk("t5_rst_addr", mis_addr, 0);
        chk("t5_rst_status", {ref_ready, mismatch, ovf, tout, done, pass}, 0);
        do_reset();
        put_dut(mk(0, 4, 4));
        put_ref(mk(0, 4, 4));
        tick();
        repeat (2) tick();
        chk("t5_match", match_cnt, 1);
        chk("t5_err", err_cnt, 0);

        // Randomized lockstep traffic with occasional corrupted model data
        do_reset();
        n_inj = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(9) < 6 && mdq.size() < DEPTH - 3) begin
                c.kind = 1'($urandom_range(1));
                c.addr = ($urandom_range(7) == 0) ? '0 : DW'($urandom);
                c.data = DW'($urandom);
                put_dut(c);
                if (c.kind || c.addr != '0) mirror.push_back(c);
            end
            if (ref_ready && mirror.size() > 0 && $urandom_range(9) < 6) begin
                c = mirror.pop_front();
                if ($urandom_range(15) == 0) begin
                    c.data = c.data ^ DW'(1);
                    n_inj++;
                end
                put_ref(c);
            end else if (ref_ready && $urandom_range(9) == 0) begin
                put_ref(mk(0, 0, DW'($urandom)));
            end
            tick();
        end
        n = 0;
        while (mirror.size() > 0 && n < 4 * DEPTH) begin
            put_ref(mirror.pop_front());
            tick();
            n++;
        end
        repeat (4) tick();
        chk("rnd_sb_drained", exp_q.size(), 0);
        chk("rnd_match", match_cnt, pairs_eq);
        chk("rnd_err", err_cnt, pairs_ne);
        chk("rnd_ovf", ovf, 0);
        drain = 1'b1;
        wait_done("rnd_done", 10);
        chk("rnd_pass", pass, (pairs_ne == 0));
        drain = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
